multi_input_conditioner: RTL

- N-channel successor to the single-pin input conditioner. Each channel is synchronised, debounced over T consecutive agreeing cycles, and edge-detected.
- Adds features the single-pin block lacks: configurable synchroniser depth, synchronous reset, long-press ("held") detection and an aggregated any-edge flag.
- Sits between raw board pins (buttons/switches) and control FSMs; all outputs are in the clk domain.

---
 rtl/multi_input_conditioner_pkg.sv | 15 +
 rtl/multi_input_conditioner_channel.sv | 77 +++++++
 rtl/multi_input_conditioner.sv | 39 +++
 3 files changed

// File: rtl/multi_input_conditioner_pkg.sv
// Shared timing defaults for the input conditioner family, so every user of the
// block debounces, synchronises and detects long presses with the same numbers.
package multi_input_conditioner_pkg;

   localparam int COND_N_DEFAULT    = 4;
   localparam int COND_T_DEFAULT    = 4;
   localparam int COND_SYNC_DEFAULT = 2;
   localparam int COND_HOLD_DEFAULT = 16;

   // A debounce length of 1 still needs a 1-bit counter.
   function automatic int cnt_width(input int t);
      return (t > 1) ? $clog2(t) : 1;
   endfunction

endpackage

// File: rtl/multi_input_conditioner_channel.sv
// One conditioner channel: synchroniser chain, T-cycle debounce, registered
// edge pulses and a saturating long-press ("held") detector.
module conditioner_channel
   import multi_input_conditioner_pkg::*;
#(
   parameter int T    = COND_T_DEFAULT,
   parameter int SYNC = COND_SYNC_DEFAULT,
   parameter int HOLD = COND_HOLD_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic conditioned,
   output logic rising,
   output logic falling,
   output logic held
);

   localparam int CW = cnt_width(T);
   localparam int HW = $clog2(HOLD + 1);

   logic [SYNC-1:0] sync_q;
   logic [CW-1:0]   cnt;
   logic [HW-1:0]   hcnt;
   logic            s;
   logic            update;

   assign s      = sync_q[SYNC-1];
   assign update = (s != conditioned) && (cnt == CW'(T - 1));

   // NOTE: reset is sampled on the clock edge and wins over every other update
   // in the same cycle; all state here is flops, so it is cleared explicitly.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         cnt         <= '0;
         hcnt        <= '0;
         conditioned <= 1'b0;
         rising      <= 1'b0;
         falling     <= 1'b0;
         held        <= 1'b0;
      end else begin
         sync_q[0] <= pin;
         for (int i = 1; i < SYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
         end

         rising  <= update & s;
         falling <= update & ~s;

         // Any agreeing cycle restarts the mismatch run.
         if (s == conditioned) begin
            cnt <= '0;
         end else if (update) begin
            conditioned <= s;
            cnt         <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end

         // The hold counter starts the cycle after the rise and clears on the
         // same edge the level falls.
         if (conditioned && !update) begin
            if (hcnt != HW'(HOLD)) begin
               hcnt <= hcnt + HW'(1);
            end
            if (hcnt >= HW'(HOLD - 1)) begin
               held <= 1'b1;
            end
         end else begin
            hcnt <= '0;
            held <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/multi_input_conditioner.sv
// N independent conditioner channels plus an aggregated any-edge flag; every
// output is registered in the clk domain except the final OR of the pulses.
module multi_input_conditioner
   import multi_input_conditioner_pkg::*;
#(
   parameter int N    = COND_N_DEFAULT,
   parameter int T    = COND_T_DEFAULT,
   parameter int SYNC = COND_SYNC_DEFAULT,
   parameter int HOLD = COND_HOLD_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] pin,
   output logic [N-1:0] conditioned,
   output logic [N-1:0] rising,
   output logic [N-1:0] falling,
   output logic [N-1:0] held,
   output logic         any_edge
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      conditioner_channel #(
         .T    (T),
         .SYNC (SYNC),
         .HOLD (HOLD)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .pin         (pin[i]),
         .conditioned (conditioned[i]),
         .rising      (rising[i]),
         .falling     (falling[i]),
         .held        (held[i])
      );
   end

   assign any_edge = |(rising | falling);

endmodule
